// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, register-zero and write-back source encodings.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter owning the last-grant flop.
module rr_arb2
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       last
);
  logic last_q, last_d;
  always_comb begin
    gnt[0] = rst_n && req[0] && (!req[1] || last_q == SRC_B);
    gnt[1] = rst_n && req[1] && (!req[0] || last_q == SRC_A);
    last_d = gnt[1] ? SRC_B : gnt[0] ? SRC_A : last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= SRC_B;
    else last_q <= last_d;
  end
  assign last = last_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back into the register file plus pending-write scoreboard.
// Optional WB_FWD_EN adds write-stage forwarding compare ports.
module regfile_wb_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [DATA_W-1:0]    a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [DATA_W-1:0]    b_data,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  input  logic                 rsv_valid,
  input  logic [ADDR_W-1:0]    rsv_addr,
  output logic [2**ADDR_W-1:0] busy_mask,
`ifdef WB_FWD_EN
  input  logic [ADDR_W-1:0]    fwd_addr1,
  input  logic [ADDR_W-1:0]    fwd_addr2,
  output logic                 fwd_hit1,
  output logic                 fwd_hit2,
`endif
  output logic                 last_src
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [NREG-1:0] ONE = NREG'(1);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);
  logic [1:0] gnt;
  logic last, g_any;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  logic rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0] busy_q, busy_d;
  rr_arb2 u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  ({b_valid, a_valid}),
    .gnt  (gnt),
    .last (last)
  );
  // Register-zero grants still consume a turn but never reach the file.
  always_comb begin
    g_any = |gnt;
    g_addr = gnt[1] ? b_addr : a_addr;
    g_data = gnt[1] ? b_data : a_data;
    rf_we_d = g_any && g_addr != ZERO_A;
    rf_waddr_d = rf_we_d ? g_addr : rf_waddr_q;
    rf_wdata_d = rf_we_d ? g_data : rf_wdata_q;
    busy_d = (busy_q & ~(g_any ? ONE << g_addr : {NREG{1'b0}})) | (rsv_valid ? ONE << rsv_addr : {NREG{1'b0}});
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q <= busy_d;
    end
  end
  assign a_ready = gnt[0];
  assign b_ready = gnt[1];
  assign rf_we = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy_mask = busy_q;
  assign last_src = last;
`ifdef WB_FWD_EN
  assign fwd_hit1 = rf_we_q && rf_waddr_q == fwd_addr1 && fwd_addr1 != ZERO_A;
  assign fwd_hit2 = rf_we_q && rf_waddr_q == fwd_addr2 && fwd_addr2 != ZERO_A;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: randomized scoreboard bench for the write-back arbiter.
module tb_regfile_wb_arbiter;
  logic clk = 0;
  logic rst_n = 0;
  logic a_valid = 0, b_valid = 0, rsv_valid = 0;
  logic [4:0] a_addr = 0, b_addr = 0, rsv_addr = 0;
  logic [31:0] a_data = 0, b_data = 0;
  logic a_ready, b_ready, rf_we, last_src;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata, busy_mask;
`ifdef WB_FWD_EN
  logic [4:0] fwd_addr1 = 0, fwd_addr2 = 0;
  logic fwd_hit1, fwd_hit2;
`endif
  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .busy_mask(busy_mask),
`ifdef WB_FWD_EN
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
`endif
    .last_src(last_src)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] busy;
    logic        last;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  logic mlast = 1'b1;
  logic [31:0] mbusy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic rv, input logic [4:0] ra, output logic ga, output logic gb);
    exp_t e;
    logic [4:0] ga_addr;
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    rsv_valid = rv; rsv_addr = ra;
    #3;
    ga = av && (!bv || mlast == 1'b1);
    gb = bv && (!av || mlast == 1'b0);
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    e.we = 0; e.addr = 0; e.data = 0;
    if (ga || gb) begin
      ga_addr = gb ? ba : aa;
      mlast = gb;
      mbusy[ga_addr] = 1'b0;
      e.we = ga_addr != 0;
      e.addr = ga_addr;
      e.data = gb ? bd : ad;
    end
    if (rv) mbusy[ra] = 1'b1;
    mbusy[0] = 1'b0;
    e.busy = mbusy;
    e.last = mlast;
    q.push_back(e);
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rf_we", rf_we, e.we);
      if (e.we) begin
        chk("rf_waddr", rf_waddr, e.addr);
        chk("rf_wdata", rf_wdata, e.data);
      end
      chk("busy_mask", busy_mask, e.busy);
      chk("last_src", last_src, e.last);
`ifdef WB_FWD_EN
      fwd_addr1 = $urandom_range(0, 1) ? e.addr : 5'($urandom);
      fwd_addr2 = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
      #1;
      chk("fwd_hit1", fwd_hit1, e.we && e.addr == fwd_addr1 && fwd_addr1 != 0);
      chk("fwd_hit2", fwd_hit2, e.we && e.addr == fwd_addr2 && fwd_addr2 != 0);
`endif
    end
  end

  initial begin
    logic ga, gb, pa, pb;
    logic [4:0] paa, pba;
    logic [31:0] pad, pbd;
    a_valid = 1; b_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_last", last_src, 1);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    @(negedge clk);
    rst_n = 1; a_valid = 0; b_valid = 0;
    cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, ga, gb);
    repeat (4) cycle(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, ga, gb);
    cycle(1, 0, 32'h1234, 0, 0, 0, 0, 0, ga, gb);
    cycle(0, 0, 0, 0, 0, 0, 1, 7, ga, gb);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
    cycle(0, 0, 0, 1, 7, 32'h77, 0, 0, ga, gb);
    cycle(0, 0, 0, 0, 0, 0, 1, 9, ga, gb);
    cycle(1, 9, 32'h99, 0, 0, 0, 1, 9, ga, gb);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
    pa = 0; pb = 0; paa = 0; pba = 0; pad = 0; pbd = 0;
    for (int i = 0; i < 400; i++) begin
      logic rv;
      logic [4:0] ra;
      if (!pa && $urandom_range(0, 1) == 1) begin
        pa = 1;
        paa = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
        pad = $urandom;
      end
      if (!pb && $urandom_range(0, 1) == 1) begin
        pb = 1;
        pba = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
        pbd = $urandom;
      end
      rv = $urandom_range(0, 3) == 0;
      ra = 5'($urandom_range(0, 7));
      cycle(pa, paa, pad, pb, pba, pbd, rv, ra, ga, gb);
      if (ga) pa = 0;
      if (gb) pb = 0;
    end
    for (int r = 8; r < 12; r++) cycle(0, 0, 0, 0, 0, 0, 1, 5'(r), ga, gb);
    cycle(1, 5, 32'h55, 0, 0, 0, 0, 0, ga, gb);
    #2;
    a_valid = 1; b_valid = 1;
    rst_n = 0;
    #1;
    chk("arst_rf_we", rf_we, 0);
    chk("arst_rf_waddr", rf_waddr, 0);
    chk("arst_rf_wdata", rf_wdata, 0);
    chk("arst_busy", busy_mask, 0);
    chk("arst_last", last_src, 1);
    chk("arst_a_ready", a_ready, 0);
    chk("arst_b_ready", b_ready, 0);
    q.delete();
    mlast = 1; mbusy = 0;
    @(negedge clk);
    rst_n = 1;
    a_valid = 0; b_valid = 0;
    cycle(1, 3, 32'h33, 1, 4, 32'h44, 0, 0, ga, gb);
    cycle(1, 3, 32'h33, 1, 4, 32'h44, 0, 0, ga, gb);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
